// File: rtl/psx_host_poller.sv
// PSX pad poller: issues 01 42 00 00 00 with att/clk/cmd, samples data, paces bytes on ack.
// Latency: one frame per accepted start, done pulses at frame end; start ignored while busy.
module psx_host_poller #(
    parameter int CLK_DIV     = 8,
    parameter int ATT_SETUP   = 16,
    parameter int ACK_TIMEOUT = 256,
    parameter int GAP_CYCLES  = 8,
    parameter int ATT_HOLD    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err_ack,
    output logic        err_id,
    output logic [7:0]  id,
    output logic [15:0] buttons,
    output logic        psx_att,
    output logic        psx_clk,
    output logic        psx_cmd,
    input  logic        psx_data,
    input  logic        psx_ack
);
    localparam int M1   = (ACK_TIMEOUT > ATT_SETUP) ? ACK_TIMEOUT : ATT_SETUP;
    localparam int M2   = (GAP_CYCLES > ATT_HOLD) ? GAP_CYCLES : ATT_HOLD;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int CMAX = (M3 > CLK_DIV) ? M3 : CLK_DIV;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SETUP    = 4'd1;
    localparam logic [3:0] S_BIT_LO   = 4'd2;
    localparam logic [3:0] S_BIT_HI   = 4'd3;
    localparam logic [3:0] S_ACK_WAIT = 4'd4;
    localparam logic [3:0] S_ACK_REL  = 4'd5;
    localparam logic [3:0] S_GAP      = 4'd6;
    localparam logic [3:0] S_HOLD     = 4'd7;
    localparam logic [3:0] S_FINISH   = 4'd8;

    function automatic logic cmd_bit(input logic [2:0] b, input logic [2:0] i);
        logic [7:0] v;
        case (b)
            3'd0:    v = 8'h01;
            3'd1:    v = 8'h42;
            default: v = 8'h00;
        endcase
        return v[i];
    endfunction

    logic          data_m_q, data_s_q, ack_m_q, ack_s_q;
    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    byte_q, byte_d, bit_q, bit_d;
    logic [7:0]    rx_q, rx_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d, b4_q, b4_d;
    logic          att_q, att_d, pclk_q, pclk_d, cmd_q, cmd_d;
    logic          busy_q, busy_d, done_q, done_d, err_ack_q, err_ack_d, err_id_q, err_id_d;
    logic [7:0]    id_q, id_d;
    logic [15:0]   buttons_q, buttons_d;
    logic [CW-1:0] cnt_inc;

    // Both controller inputs are asynchronous; only the second stage is ever looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_m_q <= 1'b1;
            data_s_q <= 1'b1;
            ack_m_q  <= 1'b1;
            ack_s_q  <= 1'b1;
        end else begin
            data_m_q <= psx_data;
            data_s_q <= data_m_q;
            ack_m_q  <= psx_ack;
            ack_s_q  <= ack_m_q;
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        b3_d      = b3_q;
        b4_d      = b4_q;
        att_d     = att_q;
        pclk_d    = pclk_q;
        cmd_d     = cmd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_ack_d = err_ack_q;
        err_id_d  = err_id_q;
        id_d      = id_q;
        buttons_d = buttons_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETUP;
                    att_d     = 1'b0;
                    busy_d    = 1'b1;
                    err_ack_d = 1'b0;
                    err_id_d  = 1'b0;
                    cnt_d     = '0;
                    byte_d    = 3'd0;
                    bit_d     = 3'd0;
                end
            end
            S_SETUP: begin
                cnt_d = cnt_inc;
                if (cnt_q == CW'(ATT_SETUP - 1)) begin
                    state_d = S_BIT_LO;
                    cnt_d   = '0;
                    pclk_d  = 1'b0;
                    cmd_d   = cmd_bit(byte_q, bit_q);
                end
            end
            S_BIT_LO: begin
                cnt_d = cnt_inc;
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d     = S_BIT_HI;
                    cnt_d       = '0;
                    pclk_d      = 1'b1;
                    rx_d[bit_q] = data_s_q;
                end
            end
            S_BIT_HI: begin
                cnt_d = cnt_inc;
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_BIT_LO;
                        pclk_d  = 1'b0;
                        cmd_d   = cmd_bit(byte_q, bit_q + 3'd1);
                    end else begin
                        case (byte_q)
                            3'd1:    b1_d = rx_q;
                            3'd2:    b2_d = rx_q;
                            3'd3:    b3_d = rx_q;
                            3'd4:    b4_d = rx_q;
                            default: ;
                        endcase
                        cmd_d   = 1'b1;
                        state_d = (byte_q == 3'd4) ? S_HOLD : S_ACK_WAIT;
                    end
                end
            end
            S_ACK_WAIT, S_ACK_REL: begin
                // One timeout budget covers both the ack fall and its release.
                if ((state_q == S_ACK_WAIT) && !ack_s_q) begin
                    state_d = S_ACK_REL;
                    cnt_d   = cnt_inc;
                end else if ((state_q == S_ACK_REL) && ack_s_q) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_FINISH;
                    att_d     = 1'b1;
                    err_ack_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                cnt_d = cnt_inc;
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_BIT_LO;
                    cnt_d   = '0;
                    byte_d  = byte_q + 3'd1;
                    bit_d   = 3'd0;
                    pclk_d  = 1'b0;
                    cmd_d   = cmd_bit(byte_q + 3'd1, 3'd0);
                end
            end
            S_HOLD: begin
                cnt_d = cnt_inc;
                if (cnt_q == CW'(ATT_HOLD - 1)) begin
                    state_d = S_FINISH;
                    att_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if ((b1_q != 8'h41) || (b2_q != 8'h5A)) begin
                        err_id_d = 1'b1;
                    end else begin
                        id_d      = b1_q;
                        buttons_d = {b4_q, b3_q};
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            byte_q    <= 3'd0;
            bit_q     <= 3'd0;
            rx_q      <= 8'h00;
            b1_q      <= 8'h00;
            b2_q      <= 8'h00;
            b3_q      <= 8'h00;
            b4_q      <= 8'h00;
            att_q     <= 1'b1;
            pclk_q    <= 1'b1;
            cmd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ack_q <= 1'b0;
            err_id_q  <= 1'b0;
            id_q      <= 8'h00;
            buttons_q <= 16'hFFFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            rx_q      <= rx_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            b3_q      <= b3_d;
            b4_q      <= b4_d;
            att_q     <= att_d;
            pclk_q    <= pclk_d;
            cmd_q     <= cmd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_ack_q <= err_ack_d;
            err_id_q  <= err_id_d;
            id_q      <= id_d;
            buttons_q <= buttons_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err_ack = err_ack_q;
    assign err_id  = err_id_q;
    assign id      = id_q;
    assign buttons = buttons_q;
    assign psx_att = att_q;
    assign psx_clk = pclk_q;
    assign psx_cmd = cmd_q;
endmodule

// File: tb/tb_psx_host_poller.sv
// Bench for psx_host_poller: behavioural pad model plus frame-level expectations.
module tb_psx_host_poller;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err_ack, err_id;
    logic [7:0]  id;
    logic [15:0] buttons;
    logic        psx_att, psx_clk, psx_cmd;
    logic        psx_data = 1'b1;
    logic        psx_ack = 1'b1;

    always #5 clk = ~clk;

    psx_host_poller #(
        .CLK_DIV(CLK_DIV), .ATT_SETUP(16), .ACK_TIMEOUT(256), .GAP_CYCLES(8), .ATT_HOLD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err_ack(err_ack), .err_id(err_id), .id(id), .buttons(buttons),
        .psx_att(psx_att), .psx_clk(psx_clk), .psx_cmd(psx_cmd),
        .psx_data(psx_data), .psx_ack(psx_ack)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pad model state
    logic [7:0] resp [0:4];
    logic [7:0] cap  [0:4];
    bit   ack_en = 1'b1;
    int   m_byte = 0, m_bit = 0, rise_cnt = 0, ack_timer = 0, ack_low = 0;
    int   cyc = 0, t_b0 = 0, t_att_hi = 0, done_cnt = 0;
    logic prev_att = 1'b1, prev_pclk = 1'b1;

    // Expected sticky results
    logic [7:0]  exp_id  = 8'h00;
    logic [15:0] exp_btn = 16'hFFFF;

    always @(negedge clk) if (done) done_cnt++;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!psx_att && prev_att) begin
            m_byte = 0; m_bit = 0; rise_cnt = 0; ack_timer = 0; ack_low = 0; psx_ack = 1'b1;
        end
        if (psx_att && !prev_att) t_att_hi = cyc;
        if (!psx_att && prev_pclk && !psx_clk && m_byte < 5) psx_data = resp[m_byte][m_bit];
        if (!psx_att && !prev_pclk && psx_clk && m_byte < 5) begin
            cap[m_byte][m_bit] = psx_cmd;
            rise_cnt++;
            if (m_bit == 7) begin
                if (m_byte == 0) t_b0 = cyc;
                if (m_byte < 4 && ack_en) ack_timer = 10;
                m_bit = 0;
                m_byte++;
            end else begin
                m_bit++;
            end
        end
        if (ack_low > 0) begin
            ack_low--;
            if (ack_low == 0) psx_ack = 1'b1;
        end else if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0) begin
                psx_ack = 1'b0;
                ack_low = 2;
            end
        end
        prev_att  = psx_att;
        prev_pclk = psx_clk;
    end

    task automatic run_frame(input bit poke_busy, input bit start_on_done);
        int n;
        int d0;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            start = (poke_busy && n == 50);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_seen", 32'(n < 3000), 1);
        if (start_on_done) start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("busy_idle", busy, 0);
    endtask

    // Frame outcome derived from what the pad returned
    task automatic expect_frame(input string nm);
        logic e_ack, e_id;
        if (!ack_en) begin
            e_ack = 1'b1; e_id = 1'b0;
        end else if (resp[1] != 8'h41 || resp[2] != 8'h5A) begin
            e_ack = 1'b0; e_id = 1'b1;
        end else begin
            e_ack = 1'b0; e_id = 1'b0;
            exp_id  = resp[1];
            exp_btn = {resp[4], resp[3]};
        end
        check({nm, "_err_ack"}, err_ack, e_ack);
        check({nm, "_err_id"}, err_id, e_id);
        check({nm, "_id"}, id, exp_id);
        check({nm, "_buttons"}, buttons, exp_btn);
        check({nm, "_att"}, psx_att, 1);
        check({nm, "_pclk"}, psx_clk, 1);
    endtask

    task automatic good_resp();
        resp[0] = 8'hFF; resp[1] = 8'h41; resp[2] = 8'h5A; resp[3] = 8'h7F; resp[4] = 8'hFF;
    endtask

    initial begin
        int n;
        int lat;
        int mode;
        logic [7:0] r;
        logic [7:0] cmd_exp [0:4];
        cmd_exp[0] = 8'h01; cmd_exp[1] = 8'h42; cmd_exp[2] = 8'h00; cmd_exp[3] = 8'h00; cmd_exp[4] = 8'h00;
        good_resp();

        repeat (3) @(negedge clk);
        check("rst_att", psx_att, 1);
        check("rst_pclk", psx_clk, 1);
        check("rst_cmd", psx_cmd, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_ack", err_ack, 0);
        check("rst_err_id", err_id, 0);
        check("rst_id", id, 8'h00);
        check("rst_buttons", buttons, 16'hFFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic good frame plus command byte capture
        run_frame(0, 0);
        expect_frame("good");
        for (int i = 0; i < 5; i++) check($sformatf("cmd_byte%0d", i), cap[i], cmd_exp[i]);
        check("rise_cnt", rise_cnt, 40);

        // Starts while busy and on the done cycle are ignored
        resp[3] = 8'h12; resp[4] = 8'hEF;
        run_frame(1, 1);
        expect_frame("poke");

        // No ack: timeout after byte 0
        ack_en = 1'b0;
        run_frame(0, 0);
        expect_frame("timeout");
        lat = t_att_hi - t_b0;
        check("to_latency_ok", 32'(lat >= 256 && lat <= 258 + CLK_DIV), 1);
        check("to_rises", rise_cnt, 8);
        ack_en = 1'b1;

        // Bad ID, then recovery
        resp[1] = 8'h73;
        run_frame(0, 0);
        expect_frame("bad_id");
        good_resp();
        run_frame(0, 0);
        expect_frame("recover");

        // Reset during bit 3 of byte 2
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(m_byte == 2 && m_bit == 3 && !psx_att) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte2", 32'(n < 3000), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_att", psx_att, 1);
        check("mid_rst_pclk", psx_clk, 1);
        check("mid_rst_cmd", psx_cmd, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_buttons", buttons, 16'hFFFF);
        exp_id = 8'h00; exp_btn = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        resp[3] = 8'hA5; resp[4] = 8'h3C;
        run_frame(0, 0);
        expect_frame("post_rst");

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            good_resp();
            resp[3] = 8'($urandom);
            resp[4] = 8'($urandom);
            mode = $urandom_range(0, 5);
            if (mode == 0) ack_en = 1'b0;
            if (mode == 1) begin
                do r = 8'($urandom); while (r == 8'h41);
                resp[1] = r;
            end
            if (mode == 2) begin
                do r = 8'($urandom); while (r == 8'h5A);
                resp[2] = r;
            end
            run_frame(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            expect_frame($sformatf("rand%0d", k));
            ack_en = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/psx_host_poller.md
Name: psx_host_poller

Overview:
- Console-side initiator for the PSX controller serial link: drives psx_att, psx_clk and psx_cmd, samples psx_data, and waits for the controller's psx_ack pulse between bytes.
- On each start request it runs one 5-byte digital-pad poll frame and returns the 16 button bits, with ID and ack-timeout checks.
- Sits between system logic and a real or emulated controller.

Parameters:
- CLK_DIV, 8: system clocks per psx_clk half-period; must be >= 4.
- ATT_SETUP, 16: clocks from psx_att falling to the first psx_clk falling edge.
- ACK_TIMEOUT, 256: maximum clocks to wait for psx_ack low after bytes 0-3.
- GAP_CYCLES, 8: clocks after psx_ack returns high before the next byte starts.
- ATT_HOLD, 8: clocks after the last bit before psx_att returns high.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request for a poll frame; ignored while busy=1.
- busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
- done  output  1  one-cycle pulse at the end of a frame, whether it succeeded or failed.
- err_ack  output  1  last frame aborted on ack timeout; held until the next start is accepted.
- err_id  output  1  last frame returned a bad ID or 0x5A byte; held until the next start is accepted.
- id  output  8  controller ID byte from the last good frame.
- buttons  output  16  {byte4, byte3} from the last good frame; raw, active-low.
- psx_att  output  1  attention (chip select), active-low.
- psx_clk  output  1  serial clock; idles high.
- psx_cmd  output  1  command bit, LSB first; idles high.
- psx_data  input  1  controller data; asynchronous to clk.
- psx_ack  input  1  controller acknowledge, active-low pulse; asynchronous to clk.

Behaviour:
- Reset values: psx_att=1, psx_clk=1, psx_cmd=1, busy=0, done=0, err_ack=0, err_id=0, id=8'h00, buttons=16'hFFFF.
- Asserting rst_n mid-frame forces these values immediately and returns the FSM to IDLE.
- psx_data and psx_ack each pass through a 2-flop synchronizer (data_s, ack_s). Only the synchronized values are used.
- Command bytes, sent in order: 8'h01, 8'h42, 8'h00, 8'h00, 8'h00. A 3-bit byte index (0-4) and a 3-bit bit index (0-7) track position.
- FSM states: IDLE, SETUP, BIT_LO, BIT_HI, ACK_WAIT, ACK_REL, GAP, HOLD, FINISH.
- IDLE:
  - On start=1, go to SETUP.
  - Drive psx_att=0, busy=1, and clear err_ack and err_id.
- SETUP:
  - Count ATT_SETUP clocks, then go to BIT_LO.
- BIT_LO:
  - On entry, drive psx_clk=0 and psx_cmd=cmd_byte[bit].
  - Hold for CLK_DIV clocks, then go to BIT_HI.
- BIT_HI:
  - On entry, drive psx_clk=1 and shift data_s into the receive byte at position [bit].
  - Hold for CLK_DIV clocks.
  - If bit<7: increment bit and go to BIT_LO.
  - If bit=7: store the received byte, set psx_cmd=1, and go to ACK_WAIT for bytes 0-3 or HOLD for byte 4.
- ACK_WAIT:
  - Counter starts at 0.
  - If ack_s=0, go to ACK_REL.
  - If the counter reaches ACK_TIMEOUT with ack_s still 1: abort, drive psx_att=1, set err_ack=1, and go to FINISH.
- ACK_REL:
  - Wait for ack_s=1, bounded by the same ACK_TIMEOUT counter (same abort path).
  - Then go to GAP.
- GAP:
  - Count GAP_CYCLES, then increment the byte index, reset bit to 0, and go to BIT_LO.
- HOLD:
  - Count ATT_HOLD, then drive psx_att=1.
  - Check the frame: if byte1 != 8'h41 or byte2 != 8'h5A, set err_id=1.
  - Otherwise load id=byte1 and buttons={byte4, byte3}.
  - Go to FINISH.
- FINISH:
  - done=1 for exactly one clock, busy=0, go to IDLE.
  - A start arriving in the same cycle is ignored.
- id and buttons change only on a frame with no error.
- Byte 0 is received but not checked.
- A psx_ack pulse arriving during BIT_LO or BIT_HI is ignored.
- An early psx_ack pulse that has already ended before ACK_WAIT is lost, and the frame times out.
- Successful frame length in clocks: 1 + ATT_SETUP + 5*(16*CLK_DIV) + 4*(ack latency + GAP_CYCLES) + ATT_HOLD + 1.
- Counters are sized to hold max(ACK_TIMEOUT, ATT_SETUP, GAP_CYCLES, ATT_HOLD, CLK_DIV) and do not wrap.

Test Plan:
- Digital-pad model (ID 0x41, 0x5A, data3=8'h7F, data4=8'hFF; acks 2 clocks low, 10 clocks after each byte), CLK_DIV=4, one start -> done pulses once; err_ack=0, err_id=0; id=8'h41; buttons=16'hFF7F; psx_att=1 and psx_clk=1 afterwards.
- Same run, bench samples psx_cmd on each psx_clk rising edge -> captured bytes 01 42 00 00 00, LSB first; exactly 40 psx_clk rising edges while psx_att=0.
- Model never asserts psx_ack, ACK_TIMEOUT=256 -> after byte 0, psx_att=1 within 258 clocks of the ACK_WAIT entry; done pulses; err_ack=1; buttons keeps its previous value.
- Model returns ID 8'h73 -> done pulses, err_id=1; id and buttons hold their prior good values (16'hFF7F); the next good frame clears err_id.
- Drive rst_n low during bit 3 of byte 2 -> psx_att=1, psx_clk=1, psx_cmd=1, busy=0, buttons=16'hFFFF immediately; the next start after release runs a clean frame.
- Pulse start again while busy, and in the same cycle as done -> neither is accepted; exactly one frame and one done pulse occur.
